// File: rtl/ccsds_123b2_selfcheck_uart_reporter.sv
// rtl/ccsds_123b2_selfcheck_uart_reporter.sv - self-check result reporter sending a 10-byte ASCII frame over UART 8N1
//
// Waits for a rising edge of test_finished, latches the five self-check flags and
// transmits "CK:" + five '0'/'1' digits + CR LF, LSB first, one start and one stop bit.
// With REPEAT_CYCLES > 0 the frame is re-sent after an idle gap while test_finished stays high.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   selfcheck_*                result flags from the self-check top
//   test_finished              level input, a frame starts on its rising edge
//   uart_tx                    registered serial output, idle high
//   busy                       registered, high from frame load until return to idle
//   status_latched             {timeout, ref_finished, ref_failed, full_finished, full_failed}
//   frames_sent                completed frames, saturating at 255
module ccsds_123b2_selfcheck_uart_reporter #(
    parameter int          CLKS_PER_BIT  = 868,
    parameter int unsigned REPEAT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       selfcheck_full_failed,
    input  logic       selfcheck_full_finished,
    input  logic       selfcheck_ref_failed,
    input  logic       selfcheck_ref_finished,
    input  logic       selfcheck_timeout,
    input  logic       test_finished,
    output logic       uart_tx,
    output logic       busy,
    output logic [4:0] status_latched,
    output logic [7:0] frames_sent
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_DATA, S_STOP, S_GAP
    } state_t;

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [31:0] GAP_LAST = 32'(REPEAT_CYCLES - 1);

    state_t      state, state_next;
    logic [15:0] bit_cnt, bit_cnt_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic [3:0]  byte_idx, byte_idx_next;
    logic [31:0] gap_cnt, gap_cnt_next;
    logic        tf_prev;
    logic        rise;
    logic        bit_end;
    logic        frame_done;
    logic [7:0]  tx_byte;
    logic        tx_next;
    logic        busy_next;

    assign rise    = test_finished & ~tf_prev;
    assign bit_end = (bit_cnt == BIT_LAST);

    // State register; uart_tx/busy are registered from the next-state decode so
    // they change on the same edge as the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            bit_cnt        <= 16'd0;
            bit_idx        <= 3'd0;
            byte_idx       <= 4'd0;
            gap_cnt        <= 32'd0;
            tf_prev        <= 1'b0;
            status_latched <= 5'd0;
            frames_sent    <= 8'd0;
            uart_tx        <= 1'b1;
            busy           <= 1'b0;
        end else begin
            state    <= state_next;
            bit_cnt  <= bit_cnt_next;
            bit_idx  <= bit_idx_next;
            byte_idx <= byte_idx_next;
            gap_cnt  <= gap_cnt_next;
            tf_prev  <= test_finished;
            uart_tx  <= tx_next;
            busy     <= busy_next;
            if (state == S_LOAD) begin
                status_latched <= {selfcheck_timeout, selfcheck_ref_finished,
                                   selfcheck_ref_failed, selfcheck_full_finished,
                                   selfcheck_full_failed};
            end
            if (frame_done && frames_sent != 8'hFF) begin
                frames_sent <= frames_sent + 8'd1;
            end
        end
    end

    // Next-state and counter decode
    always_comb begin
        state_next    = state;
        bit_cnt_next  = 16'd0;
        bit_idx_next  = bit_idx;
        byte_idx_next = byte_idx;
        gap_cnt_next  = 32'd0;
        frame_done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise) state_next = S_LOAD;
            end
            S_LOAD: begin
                byte_idx_next = 4'd0;
                state_next    = S_START;
            end
            S_START: begin
                bit_cnt_next = bit_end ? 16'd0 : bit_cnt + 16'd1;
                if (bit_end) begin
                    bit_idx_next = 3'd0;
                    state_next   = S_DATA;
                end
            end
            S_DATA: begin
                bit_cnt_next = bit_end ? 16'd0 : bit_cnt + 16'd1;
                if (bit_end) begin
                    if (bit_idx == 3'd7) state_next = S_STOP;
                    else bit_idx_next = bit_idx + 3'd1;
                end
            end
            S_STOP: begin
                bit_cnt_next = bit_end ? 16'd0 : bit_cnt + 16'd1;
                if (bit_end) begin
                    if (byte_idx != 4'd9) begin
                        byte_idx_next = byte_idx + 4'd1;
                        state_next    = S_START;
                    end else begin
                        frame_done = 1'b1;
                        state_next = (REPEAT_CYCLES != 0) ? S_GAP : S_IDLE;
                    end
                end
            end
            S_GAP: begin
                gap_cnt_next = gap_cnt + 32'd1;
                if (gap_cnt == GAP_LAST) state_next = test_finished ? S_LOAD : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // Both counters restart from zero whenever a new state is entered.
        if (state_next != state) begin
            bit_cnt_next = 16'd0;
            gap_cnt_next = 32'd0;
        end
    end

    // Output decode for the state being entered
    always_comb begin
        tx_byte = 8'h00;
        case (byte_idx_next)
            4'd0: tx_byte = 8'h43;
            4'd1: tx_byte = 8'h4B;
            4'd2: tx_byte = 8'h3A;
            4'd3: tx_byte = 8'h30 + {7'd0, status_latched[0]};
            4'd4: tx_byte = 8'h30 + {7'd0, status_latched[1]};
            4'd5: tx_byte = 8'h30 + {7'd0, status_latched[2]};
            4'd6: tx_byte = 8'h30 + {7'd0, status_latched[3]};
            4'd7: tx_byte = 8'h30 + {7'd0, status_latched[4]};
            4'd8: tx_byte = 8'h0D;
            4'd9: tx_byte = 8'h0A;
            default: tx_byte = 8'h00;
        endcase
        tx_next = 1'b1;
        if (state_next == S_START)     tx_next = 1'b0;
        else if (state_next == S_DATA) tx_next = tx_byte[bit_idx_next];
        busy_next = (state_next != S_IDLE);
    end

endmodule

// File: tb/tb_ccsds_123b2_selfcheck_uart_reporter.sv
// tb/tb_ccsds_123b2_selfcheck_uart_reporter.sv - randomized self-checking bench for the UART result reporter
module tb_ccsds_123b2_selfcheck_uart_reporter;

    localparam int CA = 4;
    localparam int CC = 2;
    localparam int CAP_MAX = 1500;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] flags;
    logic [2:0] tf;
    logic [2:0] tx_w;
    logic [2:0] busy_w;
    logic [4:0] stat_w [3];
    logic [7:0] frames_w [3];

    int n_checks = 0;
    int n_pass   = 0;

    logic cap_tx   [0:CAP_MAX-1];
    logic cap_busy [0:CAP_MAX-1];

    always #5 clk = ~clk;

    ccsds_123b2_selfcheck_uart_reporter #(.CLKS_PER_BIT(CA), .REPEAT_CYCLES(0)) u_a (
        .clk(clk), .rst_n(rst_n),
        .selfcheck_full_failed(flags[0]), .selfcheck_full_finished(flags[1]),
        .selfcheck_ref_failed(flags[2]), .selfcheck_ref_finished(flags[3]),
        .selfcheck_timeout(flags[4]), .test_finished(tf[0]),
        .uart_tx(tx_w[0]), .busy(busy_w[0]), .status_latched(stat_w[0]), .frames_sent(frames_w[0])
    );

    ccsds_123b2_selfcheck_uart_reporter #(.CLKS_PER_BIT(CA), .REPEAT_CYCLES(20)) u_b (
        .clk(clk), .rst_n(rst_n),
        .selfcheck_full_failed(flags[0]), .selfcheck_full_finished(flags[1]),
        .selfcheck_ref_failed(flags[2]), .selfcheck_ref_finished(flags[3]),
        .selfcheck_timeout(flags[4]), .test_finished(tf[1]),
        .uart_tx(tx_w[1]), .busy(busy_w[1]), .status_latched(stat_w[1]), .frames_sent(frames_w[1])
    );

    ccsds_123b2_selfcheck_uart_reporter #(.CLKS_PER_BIT(CC), .REPEAT_CYCLES(1)) u_c (
        .clk(clk), .rst_n(rst_n),
        .selfcheck_full_failed(flags[0]), .selfcheck_full_finished(flags[1]),
        .selfcheck_ref_failed(flags[2]), .selfcheck_ref_finished(flags[3]),
        .selfcheck_timeout(flags[4]), .test_finished(tf[2]),
        .uart_tx(tx_w[2]), .busy(busy_w[2]), .status_latched(stat_w[2]), .frames_sent(frames_w[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference frame: "CK:" then one ASCII digit per flag, then CR LF.
    function automatic logic [7:0] exp_byte(input logic [4:0] f, input int j);
        string hdr;
        hdr = "CK:";
        if (j < 3) return hdr[j];
        if (j < 8) return (f[j-3] ? "1" : "0");
        return (j == 8) ? 8'h0D : 8'h0A;
    endfunction

    // Sample index i is taken after the (i+1)-th rising edge following the call.
    task automatic capture(input int which, input int n, input int flip_at, input logic [4:0] flip_val,
                           input int drop_at, input int pulse_at);
        for (int i = 0; i < n; i++) begin
            tick();
            cap_tx[i]   = tx_w[which];
            cap_busy[i] = busy_w[which];
            if (i == flip_at) flags = flip_val;
            if (i == drop_at) tf[which] = 1'b0;
            if (pulse_at >= 0 && i == pulse_at)     tf[which] = 1'b0;
            if (pulse_at >= 0 && i == pulse_at + 2) tf[which] = 1'b1;
        end
    endtask

    function automatic int first_zero(input int from, input int upto);
        for (int i = from; i < upto; i++) if (cap_tx[i] == 1'b0) return i;
        return -1;
    endfunction

    function automatic int count_busy(input int upto);
        int c;
        c = 0;
        for (int i = 0; i < upto; i++) if (cap_busy[i]) c++;
        return c;
    endfunction

    // Mid-bit sampling of byte j of a frame whose start bit begins at sample t0.
    function automatic logic [7:0] decode(input int t0, input int c, input int j);
        logic [7:0] b;
        b = 8'h00;
        if (t0 < 0) return b;
        for (int i = 0; i < 8; i++) b[i] = cap_tx[t0 + j*10*c + (1+i)*c + c/2];
        return b;
    endfunction

    task automatic check_frame(input string tag, input int t0, input int c, input logic [4:0] f);
        for (int j = 0; j < 10; j++)
            check_eq($sformatf("%s_byte%0d", tag, j), {24'd0, decode(t0, c, j)}, {24'd0, exp_byte(f, j)});
        check_eq($sformatf("%s_stop9", tag), {31'd0, cap_tx[(t0 < 0 ? 0 : t0) + 99*c + c/2]}, 32'd1);
    endtask

    initial begin
        logic [4:0] f;
        logic [4:0] fv;
        int exp_frames_a;

        rst_n = 1'b0;
        flags = 5'd0;
        tf    = 3'b000;
        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("rst_tx%0d", d), {31'd0, tx_w[d]}, 32'd1);
            check_eq($sformatf("rst_busy%0d", d), {31'd0, busy_w[d]}, 32'd0);
            check_eq($sformatf("rst_status%0d", d), {27'd0, stat_w[d]}, 32'd0);
            check_eq($sformatf("rst_frames%0d", d), {24'd0, frames_w[d]}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (3) tick();

        // Basic frame, fixed flags
        flags = 5'b01010;
        tf[0] = 1'b1;
        capture(0, 420, -1, 5'd0, -1, -1);
        check_eq("t1_tx_after_rise", {31'd0, cap_tx[0]}, 32'd1);
        check_eq("t1_start_latency", first_zero(0, 420), 32'd1);
        check_eq("t1_busy_cycles", count_busy(420), 32'd401);
        check_frame("t1", 1, CA, 5'b01010);
        check_eq("t1_frames", {24'd0, frames_w[0]}, 32'd1);
        check_eq("t1_status", {27'd0, stat_w[0]}, 32'b01010);
        exp_frames_a = 1;

        // Flags changed mid-frame must not affect bytes in flight
        for (int it = 0; it < 3; it++) begin
            tf[0] = 1'b0;
            repeat (3) tick();
            f  = (it == 0) ? 5'b01010 : 5'($urandom);
            fv = (it == 0) ? 5'b11111 : ~f;
            flags = f;
            tf[0] = 1'b1;
            capture(0, 410, 50, fv, -1, -1);
            exp_frames_a++;
            check_frame($sformatf("t2_%0d", it), first_zero(0, 410), CA, f);
            check_eq($sformatf("t2_%0d_status", it), {27'd0, stat_w[0]}, {27'd0, f});
            check_eq($sformatf("t2_%0d_frames", it), {24'd0, frames_w[0]}, exp_frames_a);
        end

        // Repeat mode: gap length, re-sampled flags, stop when trigger drops
        f = 5'($urandom) & 5'b01111;
        flags = f;
        tf[1] = 1'b1;
        capture(1, 1300, 405, f | 5'b10000, 830, -1);
        check_eq("t3_first_start", first_zero(0, 1300), 32'd1);
        check_frame("t3_f1", 1, CA, f);
        check_eq("t3_busy_in_gap", {31'd0, cap_busy[410]}, 32'd1);
        check_eq("t3_second_start", first_zero(401, 1300), 32'd422);
        check_frame("t3_f2", 422, CA, f | 5'b10000);
        check_eq("t3_busy_gap2", {31'd0, cap_busy[835]}, 32'd1);
        check_eq("t3_busy_after_drop", {31'd0, cap_busy[850]}, 32'd0);
        check_eq("t3_no_third", first_zero(822, 1300), 32'hFFFF_FFFF);
        check_eq("t3_frames", {24'd0, frames_w[1]}, 32'd2);
        check_eq("t3_status", {27'd0, stat_w[1]}, {27'd0, f | 5'b10000});

        // Reset in the middle of byte 4's data bits
        tf[0] = 1'b0;
        repeat (3) tick();
        f = 5'($urandom);
        flags = f;
        tf[0] = 1'b1;
        repeat (174) tick();
        check_eq("t4_busy_before_rst", {31'd0, busy_w[0]}, 32'd1);
        rst_n = 1'b0;
        tick();
        check_eq("t4_rst_tx", {31'd0, tx_w[0]}, 32'd1);
        check_eq("t4_rst_busy", {31'd0, busy_w[0]}, 32'd0);
        check_eq("t4_rst_frames", {24'd0, frames_w[0]}, 32'd0);
        rst_n = 1'b1;
        capture(0, 420, -1, 5'd0, -1, -1);
        check_eq("t4_restart_latency", first_zero(0, 420), 32'd1);
        check_frame("t4", 1, CA, f);
        check_eq("t4_frames", {24'd0, frames_w[0]}, 32'd1);

        // Trigger pulses during a frame are ignored
        tf[0] = 1'b0;
        repeat (3) tick();
        f = 5'($urandom);
        flags = f;
        tf[0] = 1'b1;
        capture(0, 900, -1, 5'd0, -1, 100);
        check_frame("t5", first_zero(0, 900), CA, f);
        check_eq("t5_one_frame_only", first_zero(401, 900), 32'hFFFF_FFFF);
        check_eq("t5_busy_cycles", count_busy(900), 32'd401);
        check_eq("t5_frames", {24'd0, frames_w[0]}, 32'd2);

        // Saturation of frames_sent: frame n completes 202*n-1 samples after the trigger
        tf[2] = 1'b1;
        for (int i = 0; i < 300*202 + 60; i++) begin
            tick();
            if (i == 100*202 + 50) check_eq("t6_frames100", {24'd0, frames_w[2]}, 32'd100);
            if (i == 255*202 - 6)  check_eq("t6_frames254", {24'd0, frames_w[2]}, 32'd254);
            if (i == 255*202 + 4)  check_eq("t6_frames255", {24'd0, frames_w[2]}, 32'd255);
        end
        check_eq("t6_saturated", {24'd0, frames_w[2]}, 32'd255);
        check_eq("t6_busy_repeat", {31'd0, busy_w[2]}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
